// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the serial adder/subtractor.
// The master drives a request and its operands. The slave returns busy/done and the result.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, s, c, ovf
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, s, c, ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor. Each clock processes one CHUNK-bit slice of the
// WIDTH-bit operands, starting with the LSB slice. The carry between slices is
// held in a register. Subtraction is done as a + ~b + 1. s/c/ovf only change on
// the completion edge, so a partial sum is never visible on s.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Stop elaboration if the parameters are illegal.
    generate
        if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("serial_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_next;
    logic [CW-1:0]    count_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] s_reg;
    logic             c_reg, ovf_reg, done_reg;

    int               chunk_base;
    logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
    logic             chunk_cout, msb_cin;
    logic             last_chunk;

    assign chunk_base = int'(count_reg) * CHUNK;
    assign a_chunk    = a_reg[chunk_base +: CHUNK];
    assign b_chunk    = b_reg[chunk_base +: CHUNK];
    assign last_chunk = (count_reg == CW'(N - 1));

    // Ripple the carry through the current slice. Also keep the carry into its top bit for the overflow flag.
    always_comb begin
        logic carry;
        carry     = carry_reg;
        msb_cin   = 1'b0;
        sum_chunk = '0;
        for (int i = 0; i < CHUNK; i++) begin
            msb_cin      = carry;
            sum_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ carry;
            carry        = (a_chunk[i] & b_chunk[i]) | (carry & (a_chunk[i] ^ b_chunk[i]));
        end
        chunk_cout = carry;
    end

    // Merge the current slice into the working result.
    always_comb begin
        res_next = res_reg;
        res_next[chunk_base +: CHUNK] = sum_chunk;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic: a start request is accepted in IDLE, and the FSM returns to IDLE after the last slice.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_chunk) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: busy covers the whole RUN phase.
    always_comb begin
        bus.busy = (state_reg == RUN);
    end

    // Datapath: latch the operands on start, step through the slices, and publish the result on the last slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            count_reg <= '0;
            carry_reg <= 1'b0;
            s_reg     <= '0;
            c_reg     <= 1'b0;
            ovf_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == IDLE) begin
                if (bus.start) begin
                    a_reg     <= bus.a;
                    b_reg     <= bus.sub ? ~bus.b : bus.b;
                    carry_reg <= bus.sub ? 1'b1 : bus.cin;
                    count_reg <= '0;
                    res_reg   <= '0;
                end
            end else begin
                res_reg   <= res_next;
                carry_reg <= chunk_cout;
                count_reg <= count_reg + CW'(1);
                if (last_chunk) begin
                    s_reg    <= res_next;
                    c_reg    <= chunk_cout;
                    ovf_reg  <= msb_cin ^ chunk_cout;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.s    = s_reg;
    assign bus.c    = c_reg;
    assign bus.ovf  = ovf_reg;
    assign bus.done = done_reg;
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub. It drives two instances: WIDTH=8 with CHUNK=1, and WIDTH=8 with CHUNK=4.
// Each accepted request pushes its expected result and completion cycle to a queue.
// A monitor pops that queue on every done pulse.
module tb_serial_addsub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_addsub_if #(.WIDTH(8)) bus0 ();
    serial_addsub_if #(.WIDTH(8)) bus1 ();

    serial_addsub #(.WIDTH(8), .CHUNK(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    serial_addsub #(.WIDTH(8), .CHUNK(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       ovf;
        int         cyc;
        string      name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic done0_prev = 1'b0;
    logic done1_prev = 1'b0;

    // Independent reference: a full 9-bit sum, with overflow taken from the operand and result sign bits.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic sub, input logic cin, input string name);
        exp_t       m;
        logic [7:0] bb;
        logic [8:0] full;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {8'b0, (sub ? 1'b1 : cin)};
        m.s    = full[7:0];
        m.c    = full[8];
        m.ovf  = (a[7] == bb[7]) && (full[7] != a[7]);
        m.cyc  = 0;
        m.name = name;
        return m;
    endfunction

    // Scoreboard for the CHUNK=1 instance.
    always @(negedge clk) begin
        if (bus0.done) begin
            checks++;
            if (q0.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done0 cyc=%0d s=%02h (no request pending)", cyc, bus0.s);
            end else begin
                exp_t e;
                e = q0.pop_front();
                if ({bus0.s, bus0.c, bus0.ovf} !== {e.s, e.c, e.ovf} || cyc != e.cyc)
                begin
                    failures++;
                    $display("FAIL %s got s=%02h c=%0b ovf=%0b cyc=%0d expected s=%02h c=%0b ovf=%0b cyc=%0d",
                             e.name, bus0.s, bus0.c, bus0.ovf, cyc, e.s, e.c, e.ovf, e.cyc);
                end else begin
                    $display("ok   %s s=%02h c=%0b ovf=%0b cyc=%0d", e.name, bus0.s, bus0.c, bus0.ovf, cyc);
                end
            end
            if (done0_prev) begin
                failures++;
                $display("FAIL done0_width got 2+ cycles expected 1 cycle at cyc=%0d", cyc);
            end
        end
        done0_prev = bus0.done;
    end

    // Scoreboard for the CHUNK=4 instance.
    always @(negedge clk) begin
        if (bus1.done) begin
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done1 cyc=%0d s=%02h (no request pending)", cyc, bus1.s);
            end else begin
                exp_t e;
                e = q1.pop_front();
                if ({bus1.s, bus1.c, bus1.ovf} !== {e.s, e.c, e.ovf} || cyc != e.cyc)
                begin
                    failures++;
                    $display("FAIL %s got s=%02h c=%0b ovf=%0b cyc=%0d expected s=%02h c=%0b ovf=%0b cyc=%0d",
                             e.name, bus1.s, bus1.c, bus1.ovf, cyc, e.s, e.c, e.ovf, e.cyc);
                end else begin
                    $display("ok   %s s=%02h c=%0b ovf=%0b cyc=%0d", e.name, bus1.s, bus1.c, bus1.ovf, cyc);
                end
            end
            if (done1_prev) begin
                failures++;
                $display("FAIL done1_width got 2+ cycles expected 1 cycle at cyc=%0d", cyc);
            end
        end
        done1_prev = bus1.done;
    end

    // Present one request and hold start across exactly one rising edge, then queue its expected result.
    task automatic do_op(input bit which, input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input logic cin, input string name);
        exp_t e;
        e = model(a, b, sub, cin, name);
        if (which) begin
            bus1.a = a; bus1.b = b; bus1.sub = sub; bus1.cin = cin; bus1.start = 1'b1;
        end else begin
            bus0.a = a; bus0.b = b; bus0.sub = sub; bus0.cin = cin; bus0.start = 1'b1;
        end
        @(posedge clk);
        #1;
        e.cyc = cyc + (which ? 2 : 8);
        if (which) begin
            q1.push_back(e);
            bus1.start = 1'b0;
        end else begin
            q0.push_back(e);
            bus0.start = 1'b0;
        end
    endtask

    // Wait, with a cycle limit, until both scoreboards are empty.
    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        bus0.start = 0; bus0.sub = 0; bus0.cin = 0; bus0.a = '0; bus0.b = '0;
        bus1.start = 0; bus1.sub = 0; bus1.cin = 0; bus1.a = '0; bus1.b = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus0.busy, bus0.done, bus0.s, bus0.c, bus0.ovf} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs0 got busy=%0b done=%0b s=%02h c=%0b ovf=%0b expected all 0",
                     bus0.busy, bus0.done, bus0.s, bus0.c, bus0.ovf);
        end
        checks++;
        if ({bus1.busy, bus1.done, bus1.s, bus1.c, bus1.ovf} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs1 got busy=%0b done=%0b s=%02h expected all 0",
                     bus1.busy, bus1.done, bus1.s);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (bus0.busy !== 1'b0 || bus0.s !== 8'h00) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%0b s=%02h expected busy=0 s=00", bus0.busy, bus0.s);
        end
        $display("test_reset done");
    endtask

    task automatic test_add;
        bit ok;
        @(negedge clk);
        do_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
        // Operand changes while the operation runs must be ignored.
        bus0.a = 8'h3C; bus0.b = 8'hC3; bus0.sub = 1'b1; bus0.cin = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (bus0.busy !== 1'b1 || bus0.done !== 1'b0 || bus0.s !== 8'h00) begin
                failures++;
                $display("FAIL add_running[%0d] got busy=%0b done=%0b s=%02h expected busy=1 done=0 s=00",
                         i, bus0.busy, bus0.done, bus0.s);
            end
        end
        @(negedge clk);
        checks++;
        if (bus0.busy !== 1'b0) begin
            failures++;
            $display("FAIL add_busy_end got busy=%0b expected 0", bus0.busy);
        end
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL add_timeout got pending=%0d expected 0", q0.size());
        end
    endtask

    task automatic test_overflow;
        bit ok;
        @(negedge clk);
        do_op(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, "ovf_7f_01");
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL overflow_timeout got pending=%0d expected 0", q0.size());
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        bit seen;
        @(negedge clk);
        do_op(1'b0, 8'h05, 8'h07, 1'b1, 1'b0, "sub_05_07");
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus0.done) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL b2b_first_done got none expected done within 20 cycles");
        end
        // This request is raised during the done cycle, while the FSM is already back in IDLE.
        do_op(1'b0, 8'h80, 8'h01, 1'b1, 1'b0, "sub_80_01_b2b");
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_timeout got pending=%0d expected 0", q0.size());
        end
    endtask

    task automatic test_ignore_start;
        bit ok;
        @(negedge clk);
        do_op(1'b0, 8'h12, 8'h34, 1'b0, 1'b0, "add_12_34_ignore");
        @(negedge clk);
        @(negedge clk);
        bus0.a = 8'hFF; bus0.b = 8'hFF; bus0.sub = 1'b1; bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL ignore_timeout got pending=%0d expected 0", q0.size());
        end
        // A second done pulse would be flagged as unexpected by the scoreboard.
        repeat (12) @(negedge clk);
        checks++;
        if (bus0.busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_idle got busy=%0b expected 0", bus0.busy);
        end
    endtask

    task automatic test_reset_abort;
        bit ok;
        @(negedge clk);
        do_op(1'b0, 8'h80, 8'h01, 1'b1, 1'b0, "abort_80_01");
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus0.busy, bus0.done, bus0.s, bus0.c, bus0.ovf} !== 12'h000) begin
            failures++;
            $display("FAIL abort_outputs got busy=%0b done=%0b s=%02h c=%0b ovf=%0b expected all 0",
                     bus0.busy, bus0.done, bus0.s, bus0.c, bus0.ovf);
        end
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (bus0.busy !== 1'b0 || bus0.s !== 8'h00) begin
            failures++;
            $display("FAIL abort_idle got busy=%0b s=%02h expected busy=0 s=00", bus0.busy, bus0.s);
        end
        drain(ok);
    endtask

    task automatic test_chunk4;
        bit ok;
        @(negedge clk);
        do_op(1'b1, 8'hA5, 8'h5A, 1'b0, 1'b1, "c4_add_a5_5a_cin");
        bus1.a = 8'h00; bus1.b = 8'h00;
        @(negedge clk);
        checks++;
        if (bus1.busy !== 1'b1 || bus1.s !== 8'h00) begin
            failures++;
            $display("FAIL c4_running got busy=%0b s=%02h expected busy=1 s=00", bus1.busy, bus1.s);
        end
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL c4_timeout got pending=%0d expected 0", q1.size());
        end
    endtask

    task automatic test_random;
        bit ok;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] ra, rb;
            logic       rs, rc;
            bit         which;
            ra    = 8'($urandom_range(0, 255));
            rb    = 8'($urandom_range(0, 255));
            rs    = 1'($urandom_range(0, 1));
            rc    = 1'($urandom_range(0, 1));
            which = (i % 3 == 2);
            @(negedge clk);
            do_op(which, ra, rb, rs, rc, $sformatf("rand%0d_%s_%02h_%02h_%0b%0b",
                  i, which ? "c4" : "c1", ra, rb, rs, rc));
            drain(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL rand%0d_timeout got pending=%0d expected 0", i, q0.size() + q1.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        test_chunk4();
        test_random();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL final_pending got %0d expected 0", q0.size() + q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised multi-cycle adder/subtractor. It is the sequential successor to the single-bit half-adder cell.
- Processes WIDTH-bit operands CHUNK bits per clock, LSB chunk first, through a chained full-adder slice and a registered carry.
- Adds carry-in, subtract mode, signed overflow flag and a start/busy/done handshake.
- Used wherever area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥2.
- CHUNK, 1, bits processed per clock; WIDTH must be an integer multiple of CHUNK (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = a+b+cin, 1 = a-b (cin ignored); sampled with start.
- cin  input  1  carry-in for add mode; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: result valid.
- s  output  WIDTH  sum/difference.
- c  output  1  carry-out (in subtract mode c=1 means no borrow).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: rst_n low immediately forces state=IDLE; busy, done, c, ovf=0; s=0; internal operand/count/carry registers=0. Applies mid-operation: the operation is aborted, no done is issued, outputs read 0.
- N = WIDTH/CHUNK. Count register is clog2(N) bits, minimum 1.
- FSM states: IDLE, RUN.
- IDLE, start=1 at edge E:
  - Latch a; latch b, or ~b when sub=1.
  - Carry register ← sub ? 1 : cin. Count ← 0. State → RUN.
- IDLE, start=0: hold. s, c, ovf keep the last result.
- RUN, each edge: add chunk[count] of A, B and the carry register.
  - Store the CHUNK sum bits into the working result at position count·CHUNK.
  - Carry register ← chunk carry-out. Count ← count+1.
- RUN, edge processing chunk N-1:
  - s ← full working result; c ← final carry.
  - ovf ← carry into MSB XOR carry out of MSB (computed inside the last chunk).
  - done ← 1; state → IDLE.
- Latency: done is high in the cycle following edge E+N. Exactly one cycle wide.
- busy = (state==RUN): high after edge E through edge E+N.
- s, c, ovf change only on the completion edge (or reset). Partial results are never visible on s.
- start while busy is ignored; no queuing, no error.
- start high in the done cycle is accepted (state is IDLE). Back-to-back throughput is one operation per N+1 cycles.
- Input changes on a, b, sub or cin during RUN have no effect.
- Wrap-around: results are modulo 2^WIDTH. Overflow beyond WIDTH is reported via c/ovf only.

Test Plan:
1. Reset (WIDTH=8, CHUNK=1): hold rst_n=0 → busy=0, done=0, s=8'h00, c=0, ovf=0. Release with no start → stays idle.
2. Add: a=8'hFF, b=8'h01, cin=0, sub=0, start one cycle → busy for 8 cycles; done pulses once, 8 cycles after the start edge; s=8'h00, c=1, ovf=0.
3. Signed overflow: a=8'h7F, b=8'h01, sub=0 → s=8'h80, c=0, ovf=1.
4. Subtract: a=8'h05, b=8'h07, sub=1 → s=8'hFE, c=0, ovf=0.
5. Subtract with overflow: a=8'h80, b=8'h01, sub=1, start asserted in the same cycle as the prior done → accepted; s=8'h7F, c=1, ovf=1.
6. Robustness and CHUNK=4:
   - start pulse at cycle 3 of a running op → ignored, result unchanged.
   - rst_n low at cycle 3 of an op → busy drops immediately, no done, s=0.
   - CHUNK=4: a=8'hA5, b=8'h5A, cin=1 → done after 2 cycles; s=8'h00, c=1, ovf=0.
